sipo_deserializer: RTL and testbench

Serial-in/parallel-out receiver. It reassembles a WIDTH-bit word from a 1-bit serial stream by shifting left (MSB-first) or right (LSB-first). It then presents the word on a valid/ready output port.
It is the receiving end of the team's 4-bit shift datapath: a serializer shifts a word out bit by bit, and this block rebuilds it. Reset and handshaking make it usable between a serial link and a parallel consumer.

---
 rtl/sipo_deserializer_if.sv | 26 ++
 rtl/sipo_deserializer.sv | 96 +++++++++
 tb/tb_sipo_deserializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out handshake bundle: serial input side plus valid/ready word output.
// The receiver takes the slave modport; the driving environment takes the master modport.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);
  logic             clr;
  logic             sin;
  logic             sin_valid;
  logic             msb_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  modport master (
    output clr, sin, sin_valid, msb_first, dout_ready,
    input  dout, dout_valid, bit_cnt, overrun
  );

  modport slave (
    input  clr, sin, sin_valid, msb_first, dout_ready,
    output dout, dout_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Rebuilds a WIDTH-bit word from a serial stream (MSB- or LSB-first) and offers it on a
// valid/ready port; a word completing while the previous one is still unconsumed is dropped.
module sipo_deserializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  sipo_deserializer_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

  state_e           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  logic             w_dir;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_done;
  logic             w_accept;

  // The first bit of a word uses the live msb_first; later bits use the latched direction.
  assign w_dir       = (r_state == StIdle) ? bus.msb_first : r_dir;
  assign w_shreg_nxt = w_dir ? {r_shreg[WIDTH-2:0], bus.sin} : {bus.sin, r_shreg[WIDTH-1:1]};
  assign w_done      = bus.sin_valid && (r_bit_cnt == LastCnt);
  assign w_accept    = r_dout_valid && bus.dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_dir        <= 1'b1;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (bus.clr) begin
      r_state      <= StIdle;
      r_dir        <= 1'b1;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (bus.sin_valid) begin
        r_shreg <= w_shreg_nxt;
        unique case (r_state)
          StIdle: begin
            r_dir     <= bus.msb_first;
            r_state   <= StShift;
            r_bit_cnt <= OneCnt;
          end
          StShift: begin
            if (w_done) begin
              r_state   <= StIdle;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + OneCnt;
            end
          end
          default: begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
          end
        endcase
      end

      // Output slot is free if empty or being consumed on this same edge.
      if (w_done) begin
        if (!r_dout_valid || bus.dout_ready) begin
          r_dout       <= w_shreg_nxt;
          r_dout_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.bit_cnt    = r_bit_cnt;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed plus randomized bench for sipo_deserializer, checked every edge against a
// queue-based word-assembly model.
module tb_sipo_deserializer;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;

  logic clk;
  logic rst_n;

  sipo_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sipo_deserializer #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: bits of the word in progress, in arrival order.
  bit      m_bits[$];
  bit      m_dir;
  int      m_dout;
  bit      m_valid;
  bit      m_overrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int assemble(input bit dir);
    int v = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (dir) v += int'(m_bits[i]) << (int'(W) - 1 - i);
      else     v += int'(m_bits[i]) << i;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_dir     = 1'b1;
    m_dout    = 0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Apply the effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    bit done;
    int word;
    done = 1'b0;
    word = 0;
    if (bus.clr) begin
      model_reset();
    end else begin
      if (bus.sin_valid) begin
        if (m_bits.size() == 0) m_dir = bus.msb_first;
        m_bits.push_back(bus.sin);
        if (m_bits.size() == int'(W)) begin
          word = assemble(m_dir);
          done = 1'b1;
          m_bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || bus.dout_ready) begin
          m_dout  = word;
          m_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end else if (m_valid && bus.dout_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},    32'(bus.dout),       32'(m_dout));
    check({tag, ".valid"},   32'(bus.dout_valid), 32'(m_valid));
    check({tag, ".bit_cnt"}, 32'(bus.bit_cnt),    32'(m_bits.size()));
    check({tag, ".overrun"}, 32'(bus.overrun),    32'(m_overrun));
  endtask

  task automatic step(input string tag, input logic c, input logic v, input logic s,
                      input logic m, input logic r);
    bus.clr        = c;
    bus.sin_valid  = v;
    bus.sin        = s;
    bus.msb_first  = m;
    bus.dout_ready = r;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [3:0] bits_in_order, input logic m,
                           input logic r);
    for (int i = 3; i >= 0; i--) step(tag, 1'b0, 1'b1, bits_in_order[i], m, r);
  endtask

  // Pulse the asynchronous reset between edges and confirm it acts immediately.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    bus.clr        = 1'b0;
    bus.sin        = 1'b0;
    bus.sin_valid  = 1'b0;
    bus.msb_first  = 1'b1;
    bus.dout_ready = 1'b0;
    rst_n          = 1'b0;
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // 1: MSB-first 1,1,0,0 -> 12, valid for one cycle
    send_word("t1", 4'b1100, 1'b1, 1'b1);
    check("t1.dout12", 32'(bus.dout), 32'd12);
    step("t1.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t1.one_cycle", 32'(bus.dout_valid), 32'd0);

    // 2: LSB-first, then direction toggled mid-word
    send_word("t2", 4'b1100, 1'b0, 1'b1);
    check("t2.dout3", 32'(bus.dout), 32'd3);
    step("t2b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t2b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("t2b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("t2b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t2b.dout3", 32'(bus.dout), 32'd3);

    // 3: backpressure and overrun
    send_word("t3", 4'b0011, 1'b1, 1'b0);
    send_word("t3", 4'b1111, 1'b1, 1'b0);
    check("t3.hold", 32'(bus.dout), 32'd3);
    check("t3.ovr", 32'(bus.overrun), 32'd1);
    step("t3.acc", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t3.sticky", 32'(bus.overrun), 32'd1);
    step("t3.clr", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // 4: back-to-back complete and accept
    send_word("t4", 4'b1010, 1'b1, 1'b1);
    check("t4.w0", 32'(bus.dout), 32'hA);
    send_word("t4", 4'b0101, 1'b1, 1'b1);
    check("t4.w1", 32'(bus.dout), 32'h5);
    check("t4.ovr", 32'(bus.overrun), 32'd0);

    // 5: gapped input then clear with sin_valid
    step("t5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("t5.gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("t5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t5.cnt2", 32'(bus.bit_cnt), 32'd2);
    step("t5.clr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t5.cnt0", 32'(bus.bit_cnt), 32'd0);
    send_word("t5", 4'b0000, 1'b1, 1'b0);
    check("t5.zero_valid", 32'(bus.dout_valid), 32'd1);

    // 6: async reset mid-word
    step("t6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("t6", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("t6", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    async_reset("t6.rst");
    send_word("t6", 4'b1100, 1'b1, 1'b1);
    check("t6.dout12", 32'(bus.dout), 32'd12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset("rnd.rst");
      step("rnd",
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
